// File: rtl/valu_pkg.sv
// Shared definitions for the vector ALU sequencer: op codes, lane count,
// FSM state encoding and the op-code legality check.
package valu_pkg;

    localparam int VLANES = 5;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_MUL = 3'b110;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // Codes 101 and 111 have no ALU function behind them.
    function automatic logic valid_op(input logic [2:0] op);
        return (op != 3'b101) && (op != 3'b111);
    endfunction

endpackage

// File: rtl/valu_chunk_ctr.sv
// Element offset / remaining-count tracker for one vector instruction.
// Produces the per-lane valid mask and the last-chunk flag.
module valu_chunk_ctr
    import valu_pkg::*;
#(
    parameter int LANES = VLANES,
    parameter int LEN_W = 6,
    parameter int AW    = 6
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             i_load,
    input  logic [LEN_W-1:0] i_len,
    input  logic             i_adv,
    output logic [AW-1:0]    o_elem_off,
    output logic [LANES-1:0] o_lane_mask,
    output logic             o_last
);

    logic [AW-1:0]    r_elem_off;
    logic [LEN_W-1:0] r_rem;

    // NOTE: sequential state uses non-blocking assignments and is cleared by the async reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_elem_off <= '0;
            r_rem      <= '0;
        end else if (i_load) begin
            r_elem_off <= '0;
            r_rem      <= i_len;
        end else if (i_adv) begin
            r_elem_off <= r_elem_off + AW'(LANES);
            r_rem      <= r_rem - LEN_W'(LANES);
        end
    end

    always_comb begin
        o_lane_mask = '0;
        for (int i = 0; i < LANES; i++) begin
            o_lane_mask[i] = (i < int'(r_rem));
        end
    end

    assign o_elem_off = r_elem_off;
    assign o_last     = (r_rem <= LEN_W'(LANES));

endmodule

// File: rtl/valu_seq.sv
// Multi-cycle sequencer feeding one vector instruction through the 5-lane ALU,
// one chunk per issue, with VMUL issues stretched by MUL_LAT wait cycles.
module valu_seq
    import valu_pkg::*;
#(
    parameter int LANES   = VLANES,
    parameter int MAX_LEN = 32,
    parameter int LEN_W   = 6,
    parameter int AW      = 6,
    parameter int MUL_LAT = 2
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    output logic             ready,
    input  logic [2:0]       op,
    input  logic [LEN_W-1:0] len,
    input  logic [AW-1:0]    src_a_base,
    input  logic [AW-1:0]    src_b_base,
    input  logic [AW-1:0]    dst_base,
    input  logic             abort,
    output logic [AW-1:0]    rd_addr_a,
    output logic [AW-1:0]    rd_addr_b,
    output logic [AW-1:0]    wr_addr,
    output logic [2:0]       valu_ctrl,
    output logic             vector_op,
    output logic [LANES-1:0] lane_mask,
    output logic             wb_en,
    output logic             busy,
    output logic             done,
    output logic             err
);

    localparam int WCW = (MUL_LAT < 1) ? 1 : $clog2(MUL_LAT + 1);

    state_t           r_state;
    state_t           w_next;
    logic [2:0]       r_op;
    logic [AW-1:0]    r_a_base;
    logic [AW-1:0]    r_b_base;
    logic [AW-1:0]    r_d_base;
    logic             r_err;
    logic [WCW-1:0]   r_wait_cnt;

    logic             w_accept;
    logic             w_reject;
    logic             w_is_mul;
    logic             w_write;
    logic             w_adv;
    logic             w_last;
    logic [AW-1:0]    w_elem_off;
    logic [LANES-1:0] w_lane_mask;

    assign w_accept = start && (r_state == ST_IDLE);
    assign w_reject = !valid_op(op) || (len > LEN_W'(MAX_LEN));
    // With no multiplier latency a VMUL chunk is written in its issue cycle.
    assign w_is_mul = (r_op == OP_MUL) && (MUL_LAT > 0);
    assign w_write  = !abort &&
                      (((r_state == ST_ISSUE) && !w_is_mul) ||
                       ((r_state == ST_WAIT) && (r_wait_cnt == WCW'(1))));
    assign w_adv    = w_write && !w_last;

    valu_chunk_ctr #(
        .LANES (LANES),
        .LEN_W (LEN_W),
        .AW    (AW)
    ) u_chunk_ctr (
        .clk         (clk),
        .reset_n     (reset_n),
        .i_load      (w_accept),
        .i_len       (len),
        .i_adv       (w_adv),
        .o_elem_off  (w_elem_off),
        .o_lane_mask (w_lane_mask),
        .o_last      (w_last)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_op       <= '0;
            r_a_base   <= '0;
            r_b_base   <= '0;
            r_d_base   <= '0;
            r_err      <= 1'b0;
            r_wait_cnt <= '0;
        end else begin
            if (w_accept) begin
                r_op     <= op;
                r_a_base <= src_a_base;
                r_b_base <= src_b_base;
                r_d_base <= dst_base;
                r_err    <= w_reject;
            end
            if ((r_state == ST_ISSUE) && w_is_mul) begin
                r_wait_cnt <= WCW'(MUL_LAT);
            end else if (r_state == ST_WAIT) begin
                r_wait_cnt <= r_wait_cnt - WCW'(1);
            end
        end
    end

    // NOTE: every combinational output gets a default first so no latch is inferred.
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    if (w_reject || (len == '0)) w_next = ST_DONE;
                    else                         w_next = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (abort)         w_next = ST_IDLE;
                else if (w_is_mul) w_next = ST_WAIT;
                else if (w_last)   w_next = ST_DONE;
            end
            ST_WAIT: begin
                if (abort)        w_next = ST_IDLE;
                else if (w_write) w_next = w_last ? ST_DONE : ST_ISSUE;
            end
            ST_DONE: w_next = ST_IDLE;
            default: w_next = ST_IDLE;
        endcase
    end

    // Addresses stay stable through WAIT because the offset only moves on a write.
    always_comb begin
        ready     = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        err       = 1'b0;
        vector_op = 1'b0;
        wb_en     = 1'b0;
        valu_ctrl = '0;
        lane_mask = '0;
        rd_addr_a = '0;
        rd_addr_b = '0;
        wr_addr   = '0;
        case (r_state)
            ST_IDLE: ready = 1'b1;
            ST_ISSUE, ST_WAIT: begin
                busy      = 1'b1;
                vector_op = 1'b1;
                valu_ctrl = r_op;
                lane_mask = w_lane_mask;
                rd_addr_a = r_a_base + w_elem_off;
                rd_addr_b = r_b_base + w_elem_off;
                wr_addr   = r_d_base + w_elem_off;
                wb_en     = w_write;
            end
            ST_DONE: begin
                done = 1'b1;
                err  = r_err;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_valu_seq.sv
// Randomized scoreboard bench for valu_seq: the driver pushes the expected
// writeback chunks and completion pulse of each instruction; a monitor pops them.
module tb_valu_seq;
    import valu_pkg::*;

    localparam int LANES   = 5;
    localparam int MAX_LEN = 32;
    localparam int LEN_W   = 6;
    localparam int AW      = 6;
    localparam int MUL_LAT = 2;

    logic             clk = 1'b0;
    logic             reset_n;
    logic             start;
    logic             ready;
    logic [2:0]       op;
    logic [LEN_W-1:0] len;
    logic [AW-1:0]    src_a_base, src_b_base, dst_base;
    logic             abort;
    logic [AW-1:0]    rd_addr_a, rd_addr_b, wr_addr;
    logic [2:0]       valu_ctrl;
    logic             vector_op;
    logic [LANES-1:0] lane_mask;
    logic             wb_en, busy, done, err;

    valu_seq #(
        .LANES(LANES), .MAX_LEN(MAX_LEN), .LEN_W(LEN_W), .AW(AW), .MUL_LAT(MUL_LAT)
    ) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .ready(ready), .op(op), .len(len),
        .src_a_base(src_a_base), .src_b_base(src_b_base), .dst_base(dst_base), .abort(abort),
        .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b), .wr_addr(wr_addr), .valu_ctrl(valu_ctrl),
        .vector_op(vector_op), .lane_mask(lane_mask), .wb_en(wb_en), .busy(busy),
        .done(done), .err(err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        bit         is_done;
        int         cyc;
        logic [5:0] a, b, d;
        logic [2:0] ctrl;
        logic [4:0] mask;
        bit         err;
    } ev_t;

    ev_t q[$];
    ev_t e;
    int  n_checks = 0;
    int  n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every vector_op cycle must match the chunk at the queue head.
    always @(negedge clk) begin
        if (vector_op && abort) begin
            check("wb_on_abort", 32'(wb_en), 32'd0);
        end else if (vector_op) begin
            if (q.size() == 0 || q[0].is_done) begin
                check("unexpected_vop", 32'(vector_op), 32'd0);
            end else begin
                e = q[0];
                check("rd_addr_a", 32'(rd_addr_a), 32'(e.a));
                check("rd_addr_b", 32'(rd_addr_b), 32'(e.b));
                check("wr_addr", 32'(wr_addr), 32'(e.d));
                check("valu_ctrl", 32'(valu_ctrl), 32'(e.ctrl));
                check("lane_mask", 32'(lane_mask), 32'(e.mask));
                check("busy_in_op", 32'(busy), 32'd1);
                check("wb_timing", 32'(wb_en), 32'(e.cyc == cyc));
                if (e.cyc == cyc) void'(q.pop_front());
            end
        end else if (wb_en) begin
            check("wb_without_vop", 32'(wb_en), 32'd0);
        end

        if (done) begin
            if (q.size() == 0 || !q[0].is_done) begin
                check("unexpected_done", 32'(done), 32'd0);
            end else begin
                e = q.pop_front();
                check("done_cycle", 32'(cyc), 32'(e.cyc));
                check("done_err", 32'(err), 32'(e.err));
                check("busy_at_done", 32'(busy), 32'd0);
            end
        end else if (err) begin
            check("err_without_done", 32'(err), 32'd0);
        end

        if (q.size() > 0 && q[0].cyc < cyc) begin
            e = q.pop_front();
            check("missed_event", 32'(cyc), 32'(e.cyc));
        end
    end

    function automatic bit is_invalid(input logic [2:0] o, input int l);
        return (o == 3'b101) || (o == 3'b111) || (l > MAX_LEN);
    endfunction

    // Cycles spent in ISSUE/WAIT, from the instruction's rules alone.
    function automatic int busy_len_f(input logic [2:0] o, input int l);
        if (is_invalid(o, l) || l == 0) return 0;
        return ((l + LANES - 1) / LANES) * (1 + ((o == OP_MUL) ? MUL_LAT : 0));
    endfunction

    task automatic wait_ready();
        int n = 0;
        while (!ready && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        check("ready_before_start", 32'(ready), 32'd1);
    endtask

    task automatic push_model(input int acc, input logic [2:0] o, input int l,
                              input logic [5:0] a, input logic [5:0] b, input logic [5:0] d,
                              input int abort_k);
        int   per, nchunks, kw, rem;
        ev_t  ev;
        if (is_invalid(o, l) || l == 0) begin
            if (abort_k == 0) begin
                ev = '{is_done: 1'b1, cyc: acc, a: '0, b: '0, d: '0, ctrl: '0, mask: '0,
                       err: is_invalid(o, l)};
                q.push_back(ev);
            end
            return;
        end
        per     = 1 + ((o == OP_MUL) ? MUL_LAT : 0);
        nchunks = (l + LANES - 1) / LANES;
        for (int c = 0; c < nchunks; c++) begin
            kw = (c + 1) * per;
            if (abort_k != 0 && kw >= abort_k) break;
            rem     = l - LANES * c;
            ev      = '{is_done: 1'b0, cyc: acc + kw - 1, a: 6'(a + LANES * c),
                        b: 6'(b + LANES * c), d: 6'(d + LANES * c), ctrl: o,
                        mask: (rem >= LANES) ? 5'b11111 : 5'((1 << rem) - 1), err: 1'b0};
            q.push_back(ev);
        end
        if (abort_k == 0) begin
            ev = '{is_done: 1'b1, cyc: acc + nchunks * per, a: '0, b: '0, d: '0,
                   ctrl: '0, mask: '0, err: 1'b0};
            q.push_back(ev);
        end
    endtask

    task automatic drain();
        int n = 0;
        while (q.size() > 0 && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        check("drain_queue_empty", 32'(q.size()), 32'd0);
    endtask

    // abort_k: offset (1 = first cycle after accept) at which abort is raised, 0 for none.
    task automatic run_instr(input logic [2:0] i_op, input int i_len,
                             input logic [5:0] a, input logic [5:0] b, input logic [5:0] d,
                             input int abort_k_in, input bit spurious, input bit abort_idle);
        int acc, blen, done_k, stop_k, abort_k;
        wait_ready();
        start      = 1'b1;
        op         = i_op;
        len        = LEN_W'(i_len);
        src_a_base = a;
        src_b_base = b;
        dst_base   = d;
        abort      = abort_idle;
        @(posedge clk); #1;
        acc        = cyc;
        start      = 1'b0;
        abort      = 1'b0;
        op         = 3'($urandom);
        len        = LEN_W'($urandom);
        src_a_base = AW'($urandom);
        src_b_base = AW'($urandom);
        dst_base   = AW'($urandom);

        blen    = busy_len_f(i_op, i_len);
        done_k  = blen + 1;
        abort_k = (abort_k_in > blen) ? 0 : abort_k_in;
        push_model(acc, i_op, i_len, a, b, d, abort_k);
        stop_k  = (abort_k != 0) ? abort_k : done_k;

        for (int k = 1; k <= stop_k; k++) begin
            start = spurious && (k <= 2) && (blen >= 2);
            if (k == abort_k) abort = 1'b1;
            if (abort_idle && abort_k == 0 && k == done_k) abort = 1'b1;
            @(posedge clk); #1;
            start = 1'b0;
            abort = 1'b0;
        end
        check("ready_after_instr", 32'(ready), 32'd1);
        check("busy_after_instr", 32'(busy), 32'd0);
        drain();
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_ready"}, 32'(ready), 32'd1);
        check({tag, "_outs"}, {busy, done, err, wb_en, vector_op, valu_ctrl, lane_mask},
              32'd0);
        check({tag, "_addrs"}, {rd_addr_a, rd_addr_b, wr_addr}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int rl, rk;
        logic [2:0] ro;
        reset_n    = 1'b0;
        start      = 1'b0;
        abort      = 1'b0;
        op         = '0;
        len        = '0;
        src_a_base = '0;
        src_b_base = '0;
        dst_base   = '0;
        #3;
        check_all_zero("reset");
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
        @(posedge clk); #1;

        run_instr(OP_ADD, 12, 6'd0, 6'd16, 6'd32, 0, 1'b1, 1'b0);
        run_instr(OP_MUL, 7, 6'd3, 6'd9, 6'd20, 0, 1'b0, 1'b0);
        run_instr(OP_ADD, 0, 6'd1, 6'd2, 6'd3, 0, 1'b0, 1'b0);
        run_instr(3'b101, 5, 6'd1, 6'd2, 6'd3, 0, 1'b0, 1'b0);
        run_instr(OP_OR, 33, 6'd1, 6'd2, 6'd3, 0, 1'b0, 1'b0);
        run_instr(OP_XOR, 5, 6'd4, 6'd8, 6'd62, 0, 1'b0, 1'b0);
        run_instr(OP_ADD, 20, 6'd10, 6'd40, 6'd50, 2, 1'b0, 1'b0);
        run_instr(OP_SUB, 4, 6'd60, 6'd61, 6'd63, 0, 1'b0, 1'b0);
        run_instr(OP_AND, 3, 6'd7, 6'd8, 6'd9, 0, 1'b0, 1'b1);
        run_instr(OP_MUL, 32, 6'd33, 6'd0, 6'd5, 0, 1'b0, 1'b0);

        // Reset in the middle of a MUL wait must kill the pending writeback.
        wait_ready();
        start = 1'b1; op = OP_MUL; len = 6'd7;
        src_a_base = 6'd1; src_b_base = 6'd2; dst_base = 6'd3;
        @(posedge clk); #1;
        start = 1'b0;
        push_model(cyc, OP_MUL, 7, 6'd1, 6'd2, 6'd3, 0);
        @(posedge clk); #1;
        reset_n = 1'b0;
        q.delete();
        #1;
        check_all_zero("midwait_reset");
        @(posedge clk); #1;
        reset_n = 1'b1;
        repeat (8) @(posedge clk);
        #1;
        check("ready_after_reset", 32'(ready), 32'd1);

        for (int t = 0; t < 40; t++) begin
            ro = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 3) != 0 && (ro == 3'b101 || ro == 3'b111)) ro = OP_MUL;
            rl = ($urandom_range(0, 9) == 0) ? $urandom_range(33, 63) : $urandom_range(0, 32);
            rk = ($urandom_range(0, 4) == 0) ? $urandom_range(1, 12) : 0;
            run_instr(ro, rl, 6'($urandom), 6'($urandom), 6'($urandom), rk,
                      1'($urandom), 1'($urandom));
        end

        drain();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/valu_seq.md
Name: valu_seq

Overview:
- Multi-cycle sequencer that runs one vector instruction of arbitrary length (1..MAX_LEN elements) through the 5-lane vector ALU, one 5-element chunk per issue.
- Sits between the decode/control unit and the vector register file plus 5-lane vector ALU.
- Drives the register-file read/write element addresses, the ALU control and vector_op strobe, and the per-lane writeback mask.
- Stretches VMUL issues by MUL_LAT cycles.

Parameters:
- LANES, 5, ALU lanes per issue. Fixed; must match the vector ALU.
- MAX_LEN, 32, maximum legal element count.
- LEN_W, 6, width of len; must satisfy 2^LEN_W > MAX_LEN.
- AW, 6, element address width into the vector register file.
- MUL_LAT, 2, extra wait cycles after a VMUL issue before writeback. 0 is legal.

Ports:
- clk  in  1  clock, rising edge
- reset_n  in  1  asynchronous active-low reset
- start  in  1  request to begin an instruction
- ready  out  1  high in IDLE; start is accepted only when start && ready
- op  in  3  ALU control code: 000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 110 MUL
- len  in  LEN_W  element count
- src_a_base  in  AW  first element address, operand A
- src_b_base  in  AW  first element address, operand B
- dst_base  in  AW  first element address, destination
- abort  in  1  synchronous cancel of the instruction in flight
- rd_addr_a  out  AW  element address of lane 0, operand A (lane i = +i)
- rd_addr_b  out  AW  element address of lane 0, operand B
- wr_addr  out  AW  element address of lane 0, destination
- valu_ctrl  out  3  ALU control sent to the ALU
- vector_op  out  1  ALU enable
- lane_mask  out  LANES  lanes holding valid elements in the current chunk
- wb_en  out  1  writeback strobe; write only the lanes set in lane_mask
- busy  out  1  instruction in flight
- done  out  1  one-cycle completion pulse
- err  out  1  one-cycle pulse on a rejected instruction, coincident with done

Behaviour:
- Reset (async, reset_n=0):
  - State IDLE, ready=1.
  - All other outputs 0: busy, done, err, wb_en, vector_op, lane_mask, all addresses, valu_ctrl.
  - Internal counters 0.
- States: IDLE, ISSUE, WAIT, DONE.
- IDLE:
  - On start&&ready, latch op, len and the three bases; set elem_off=0 and rem=len.
  - If op is 101 or 111, or len > MAX_LEN: go to DONE with err.
  - Else if len==0: go to DONE with err=0 and no writeback.
  - Else: go to ISSUE.
  - start while not ready is ignored; no queuing.
- ISSUE (Moore outputs):
  - vector_op=1, valu_ctrl=op.
  - rd_addr_a = src_a_base+elem_off, rd_addr_b = src_b_base+elem_off, wr_addr = dst_base+elem_off. All sums truncate to AW bits (wrap).
  - lane_mask bit i = (i < min(rem, LANES)).
  - Non-MUL op: wb_en=1 in this same cycle.
    - If rem <= LANES, go to DONE.
    - Else elem_off += LANES, rem -= LANES, stay in ISSUE (back-to-back chunks, 1 cycle each).
  - MUL with MUL_LAT>0: wb_en=0, load wait_cnt=MUL_LAT, go to WAIT.
  - MUL with MUL_LAT=0: behaves as a non-MUL op.
- WAIT:
  - Addresses, valu_ctrl, vector_op and lane_mask are held identical to the issuing cycle.
  - wait_cnt decrements each cycle.
  - wb_en=1 only in the cycle where wait_cnt==1.
  - From that cycle, advance exactly as ISSUE does after a write.
  - MUL chunk cost: 1+MUL_LAT cycles.
- DONE:
  - done=1 for one cycle; err as latched; vector_op=0, wb_en=0.
  - Next state IDLE.
- busy=1 in ISSUE and WAIT. ready=1 only in IDLE.
- Total cycles from the accept edge to the done pulse (non-MUL): ceil(len/5) + 1.
- abort:
  - In ISSUE or WAIT: abort has priority; wb_en is forced 0 in that cycle. Next state IDLE, no done, no err.
  - In IDLE or DONE: abort is ignored.
- Partial last chunk:
  - lane_mask is e.g. 00111 for 3 remaining elements.
  - Masked-off lanes still carry address-derived values; the register file must ignore them.

Decomposition:
- Shared package valu_pkg:
  - op codes OP_ADD=3'b000, OP_SUB=3'b001, OP_AND=3'b010, OP_OR=3'b011, OP_XOR=3'b100, OP_MUL=3'b110
  - VLANES=5
  - state encoding typedef (IDLE, ISSUE, WAIT, DONE)
  - function valid_op()
- One natural sub-module: valu_chunk_ctr. It holds elem_off/rem and produces lane_mask and the last-chunk flag.
- The FSM stays in valu_seq.

Test Plan:
- ADD, len=12, bases a=0, b=16, d=32 -> three ISSUE cycles with rd_addr_a=0/5/10, wr_addr=32/37/42, lane_mask=11111/11111/00011, wb_en each cycle; done on the 4th cycle after accept.
- MUL, MUL_LAT=2, len=7 -> wb_en on cycles 3 and 6 after accept, with addresses held across each 3-cycle group; lane_mask 11111 then 00011; done at cycle 7.
- len=0, and separately op=101 -> no vector_op and no wb_en. len=0 gives done with err=0; op=101 gives done with err=1; ready returns the following cycle.
- dst_base=62, len=5, AW=6 -> wr_addr=62 with lane_mask=11111 (lanes wrap to 0..2 inside the RF); one wb_en.
- abort asserted in the 2nd ISSUE cycle of a len=20 ADD -> wb_en=0 that cycle, no done, ready=1 next cycle; an immediate new start is accepted.
- reset_n pulsed low mid-WAIT -> all outputs 0 asynchronously and ready=1 immediately, with no further writeback after release.
